// File: rtl/lcd_scaler.sv
// rtl/lcd_scaler.sv - downscales a palette-indexed source raster into an RGB565 LCD frame buffer
//
// Ports:
//   clk          system clock, all logic on rising edge
//   reset        synchronous active-high reset
//   enable       frame capture enable, sampled only together with frame_start
//   frame_start  one-cycle pulse at the start of a source frame
//   pix_valid    qualifies pix_color, one source pixel per assertion, raster order
//   pix_color    4-bit source palette index
//   ram_wr       one-cycle frame buffer write strobe
//   ram_addr     frame buffer word address (held when ram_wr=0)
//   ram_data     RGB565 pixel (held when ram_wr=0)
//   frame_done   one-cycle pulse the cycle after the final buffer write of a frame
module lcd_scaler #(
    parameter int SRC_W = 256,
    parameter int SRC_H = 192,
    parameter int DST_W = 96,
    parameter int DST_H = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [3:0]  pix_color,
    output logic        ram_wr,
    output logic [12:0] ram_addr,
    output logic [15:0] ram_data,
    output logic        frame_done
);

    localparam int XW   = $clog2(SRC_W);
    localparam int LW   = $clog2(SRC_H + 1);
    localparam int LAST = DST_W * DST_H - 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   src_x_q, src_x_d;
    logic [LW-1:0]   src_line_q, src_line_d;
    logic [9:0]      hacc_q, hacc_d;
    logic [9:0]      vacc_q, vacc_d;
    logic            line_sel_q, line_sel_d;
    logic [12:0]     wr_addr_q, wr_addr_d;
    logic            full_q, full_d;
    logic            s1_vld_q, s1_vld_d;
    logic [12:0]     s1_addr_q, s1_addr_d;
    logic [3:0]      s1_color_q, s1_color_d;
    logic            s1_last_q, s1_last_d;
    logic            ram_wr_q, ram_wr_d;
    logic [12:0]     ram_addr_q, ram_addr_d;
    logic [15:0]     ram_data_q, ram_data_d;
    logic            wr_last_q, wr_last_d;
    logic            frame_done_q, frame_done_d;

    // TMS9918 colours, 8-bit components truncated to RGB565
    function automatic logic [15:0] palette(input logic [3:0] c);
        case (c)
            4'd0:    palette = 16'h0000;
            4'd1:    palette = 16'h0000;
            4'd2:    palette = 16'h2648;
            4'd3:    palette = 16'h5EEF;
            4'd4:    palette = 16'h52BD;
            4'd5:    palette = 16'h7BBF;
            4'd6:    palette = 16'hD289;
            4'd7:    palette = 16'h475E;
            4'd8:    palette = 16'hFAAA;
            4'd9:    palette = 16'hFBCF;
            4'd10:   palette = 16'hD60A;
            4'd11:   palette = 16'hE670;
            4'd12:   palette = 16'h2587;
            4'd13:   palette = 16'hCAD7;
            4'd14:   palette = 16'hCE79;
            default: palette = 16'hFFFF;
        endcase
    endfunction

    logic        accept;
    logic        line_sel;
    logic        col_sel;
    logic [9:0]  s_sum;
    logic [9:0]  t_sum;

    always_comb begin
        state_d      = state_q;
        src_x_d      = src_x_q;
        src_line_d   = src_line_q;
        hacc_d       = hacc_q;
        vacc_d       = vacc_q;
        line_sel_d   = line_sel_q;
        wr_addr_d    = wr_addr_q;
        full_d       = full_q;
        s1_vld_d     = 1'b0;
        s1_addr_d    = s1_addr_q;
        s1_color_d   = s1_color_q;
        s1_last_d    = 1'b0;
        // stage 2 drains stage 1 even across frame_start so an in-flight write completes
        ram_wr_d     = s1_vld_q;
        ram_addr_d   = s1_vld_q ? s1_addr_q : ram_addr_q;
        ram_data_d   = s1_vld_q ? palette(s1_color_q) : ram_data_q;
        // the last-write tag is dropped by any frame_start, so an aborted frame never signals done
        wr_last_d    = s1_last_q && !frame_start;
        frame_done_d = wr_last_q && !frame_start;

        accept   = (state_q == ACTIVE) && pix_valid && !frame_start;
        s_sum    = hacc_q + 10'(DST_W);
        t_sum    = vacc_q + 10'(DST_H);
        col_sel  = (s_sum >= 10'(SRC_W));
        line_sel = line_sel_q;

        if (frame_start) begin
            state_d    = enable ? ACTIVE : IDLE;
            src_x_d    = '0;
            src_line_d = '0;
            wr_addr_d  = '0;
            full_d     = 1'b0;
            hacc_d     = 10'(SRC_W - DST_W);
            vacc_d     = 10'(SRC_H - DST_H);
            line_sel_d = 1'b0;
        end else if (accept) begin
            // line selection is decided by the first pixel of each line
            if (src_x_q == '0) begin
                line_sel   = (t_sum >= 10'(SRC_H));
                vacc_d     = line_sel ? (t_sum - 10'(SRC_H)) : t_sum;
                line_sel_d = line_sel;
            end
            hacc_d = col_sel ? (s_sum - 10'(SRC_W)) : s_sum;
            if (line_sel && col_sel && !full_q) begin
                s1_vld_d   = 1'b1;
                s1_addr_d  = wr_addr_q;
                s1_color_d = pix_color;
                s1_last_d  = (wr_addr_q == 13'(LAST));
                // saturate at the last buffer word instead of wrapping
                if (wr_addr_q == 13'(LAST)) full_d = 1'b1;
                else                        wr_addr_d = wr_addr_q + 13'd1;
            end
            if (src_x_q == XW'(SRC_W - 1)) begin
                src_x_d    = '0;
                hacc_d     = 10'(SRC_W - DST_W);
                src_line_d = src_line_q + 1'b1;
                if (src_line_q == LW'(SRC_H - 1)) state_d = IDLE;
            end else begin
                src_x_d = src_x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            src_x_q      <= '0;
            src_line_q   <= '0;
            hacc_q       <= '0;
            vacc_q       <= '0;
            line_sel_q   <= 1'b0;
            wr_addr_q    <= '0;
            full_q       <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_addr_q    <= '0;
            s1_color_q   <= '0;
            s1_last_q    <= 1'b0;
            ram_wr_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            wr_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_x_q      <= src_x_d;
            src_line_q   <= src_line_d;
            hacc_q       <= hacc_d;
            vacc_q       <= vacc_d;
            line_sel_q   <= line_sel_d;
            wr_addr_q    <= wr_addr_d;
            full_q       <= full_d;
            s1_vld_q     <= s1_vld_d;
            s1_addr_q    <= s1_addr_d;
            s1_color_q   <= s1_color_d;
            s1_last_q    <= s1_last_d;
            ram_wr_q     <= ram_wr_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            wr_last_q    <= wr_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ram_wr     = ram_wr_q;
    assign ram_addr   = ram_addr_q;
    assign ram_data   = ram_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_scaler.sv
// tb/tb_lcd_scaler.sv - directed self-checking bench for lcd_scaler
module tb_lcd_scaler;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        frame_start;
    logic        pix_valid;
    logic [3:0]  pix_color;
    logic        ram_wr;
    logic [12:0] ram_addr;
    logic [15:0] ram_data;
    logic        frame_done;

    lcd_scaler dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_color   (pix_color),
        .ram_wr      (ram_wr),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wa[$];
    int wd[$];
    int wc[$];
    int dc[$];

    always @(negedge clk) begin
        if (ram_wr === 1'b1) begin
            wa.push_back(int'(ram_addr));
            wd.push_back(int'(ram_data));
            wc.push_back(cyc);
        end
        if (frame_done === 1'b1) dc.push_back(cyc);
    end

    // TMS9918 palette in RGB565, computed by hand from the 8-bit RGB values
    int pal_t[16] = '{32'h0000, 32'h0000, 32'h2648, 32'h5EEF, 32'h52BD, 32'h7BBF,
                      32'hD289, 32'h475E, 32'hFAAA, 32'hFBCF, 32'hD60A, 32'hE670,
                      32'h2587, 32'hCAD7, 32'hCE79, 32'hFFFF};

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // column j of a row samples source x = ceil(8j/3); pixel colour is x mod 16
    function automatic int exp_data(input int addr);
        int col;
        int x;
        col = addr % 96;
        x   = (8 * col + 2) / 3;
        return pal_t[x % 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_q();
        wa.delete();
        wd.delete();
        wc.delete();
        dc.delete();
    endtask

    task automatic start(input logic en);
        frame_start = 1'b1;
        enable      = en;
        pix_valid   = 1'b0;
        tick();
        frame_start = 1'b0;
        enable      = 1'b0;
    endtask

    // color < 0 gives colour = pixel index mod 16; pct is the pix_valid duty in percent
    task automatic pixels(input int n, input int color, input int pct);
        for (int i = 0; i < n; i++) begin
            if (pct < 100) begin
                while ($urandom_range(1, 100) > pct) begin
                    pix_valid = 1'b0;
                    tick();
                end
            end
            pix_valid = 1'b1;
            pix_color = (color < 0) ? 4'(i % 16) : 4'(color);
            tick();
        end
        pix_valid = 1'b0;
    endtask

    // data < 0 selects the column-derived colour model
    task automatic check_writes(input string tag, input int base, input int n, input int data);
        int lim;
        lim = wa.size() - base;
        if (lim > n) lim = n;
        for (int k = 0; k < lim; k++) begin
            chk($sformatf("%s_addr%0d", tag, k), wa[base + k], k);
            chk($sformatf("%s_data%0d", tag, k), wd[base + k], (data < 0) ? exp_data(k) : data);
        end
    endtask

    int t0;

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_color   = 4'd0;
        tick();
        tick();
        chk("rst_wr", ram_wr, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_data", ram_data, 0);
        chk("rst_done", frame_done, 0);
        reset = 1'b0;
        tick();

        // one line of white: 96 writes, 2-cycle latency
        clear_q();
        start(1'b1);
        t0 = cyc;
        pixels(256, 15, 100);
        idle(5);
        chk("line_cnt", wa.size(), 96);
        check_writes("line", 0, 96, 32'hFFFF);
        if (wc.size() > 0) chk("line_latency", wc[0] - t0, 2);
        chk("line_done_cnt", dc.size(), 0);

        // palette: one pixel frames, column 0 of line 0 is always written
        for (int c = 0; c < 16; c++) begin
            clear_q();
            start(1'b1);
            pixels(1, c, 100);
            idle(3);
            chk($sformatf("pal_cnt%0d", c), wa.size(), 1);
            if (wa.size() > 0) chk($sformatf("pal_data%0d", c), wd[0], pal_t[c]);
        end

        // reset for one cycle mid-line with pix_valid high
        clear_q();
        start(1'b1);
        pixels(10, 5, 100);
        pix_valid = 1'b1;
        pix_color = 4'd5;
        reset     = 1'b1;
        tick();
        clear_q();
        chk("mrst_wr", ram_wr, 0);
        chk("mrst_addr", ram_addr, 0);
        chk("mrst_data", ram_data, 0);
        reset = 1'b0;
        pixels(20, 5, 100);
        idle(5);
        chk("mrst_cnt", wa.size(), 0);
        chk("mrst_done_cnt", dc.size(), 0);

        // aborted after 1000 pixels, then full frame, then trailing pixels ignored
        clear_q();
        start(1'b1);
        pixels(1000, -1, 100);
        start(1'b1);
        pixels(256 * 192, -1, 100);
        pixels(50, 7, 100);
        idle(5);
        chk("full_cnt", wa.size(), 183 + 6144);
        check_writes("abort", 0, 183, -1);
        check_writes("full", 183, 6144, -1);
        chk("full_done_cnt", dc.size(), 1);
        if (dc.size() > 0 && wc.size() > 0) chk("full_done_cyc", dc[0], wc[wc.size() - 1] + 1);
        chk("hold_wr", ram_wr, 0);
        chk("hold_addr", ram_addr, 6143);
        chk("hold_data", ram_data, 32'hCE79);

        // random pix_valid over the first 8 lines: lines 0, 3, 6 selected
        clear_q();
        start(1'b1);
        pixels(2048, -1, 50);
        idle(5);
        chk("rand_cnt", wa.size(), 288);
        check_writes("rand", 0, 288, -1);
        chk("rand_done_cnt", dc.size(), 0);

        // disabled frame
        clear_q();
        start(1'b0);
        pixels(3000, 3, 100);
        idle(5);
        chk("dis_cnt", wa.size(), 0);
        chk("dis_done_cnt", dc.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
